// File: rtl/spi_sevenseg_pkg.sv
// spi_sevenseg_pkg: shared commands, frame width, FSM states and frame encoder for the seven-segment SPI link
package spi_sevenseg_pkg;
   localparam logic [1:0] CMD_SEG    = 2'b10;
   localparam logic [1:0] CMD_SEG_DP = 2'b01;
   localparam logic [1:0] CMD_BLANK  = 2'b00;
   localparam int FRAME_BITS = 6;
   typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, GAP} spi_tx_state_t;
   // Blank wins over dp and data; the blank frame always carries a zero digit.
   function automatic logic [5:0] encode_frame(input logic i_blank, input logic i_dp, input logic [3:0] i_data);
      return i_blank ? {CMD_BLANK, 4'h0} : {(i_dp ? CMD_SEG_DP : CMD_SEG), i_data};
   endfunction
endpackage

// File: rtl/spi_sevenseg_master_clk_div.sv
// spi_clk_div: sclk phase timer, o_phase_end high in the last of CLK_DIV cycles after i_start
// Ports: clk, rst_n (sync, active low), i_start reloads the timer, o_phase_end marks the end of a phase.
module spi_clk_div #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_start,
   output logic o_phase_end
);
   localparam int W = $clog2(CLK_DIV) + 1;
   logic [W-1:0] r_cnt;
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_cnt <= '0;
      else if (i_start)
         r_cnt <= W'(CLK_DIV - 1);
      else if (r_cnt != '0)
         r_cnt <= r_cnt - W'(1);
   end
   assign o_phase_end = (r_cnt == '0);
endmodule

// File: rtl/spi_sevenseg_master.sv
// spi_sevenseg_master: SPI mode-0 master sending 6-bit {cmd, digit} frames MSB first to a seven-segment slave
// Ports: clk, rst_n (sync, active low); in_valid/in_ready handshake with in_data, in_dp, in_blank;
//        spi_sclk/spi_ss/spi_mosi serial link; busy while a frame is in flight; done pulses as spi_ss rises.
module spi_sevenseg_master
   import spi_sevenseg_pkg::*;
#(
   parameter int CLK_DIV = 2,
   parameter int GAP     = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_data,
   input  logic       in_dp,
   input  logic       in_blank,
   output logic       spi_sclk,
   output logic       spi_ss,
   output logic       spi_mosi,
   output logic       busy,
   output logic       done
);
   localparam int GW = $clog2(GAP + 1) + 1;
   spi_tx_state_t r_state, w_state_nxt;
   logic [5:0]    r_shift, w_shift_nxt;
   logic [2:0]    r_bit, w_bit_nxt;
   logic [GW-1:0] r_gap, w_gap_nxt;
   logic r_sclk, w_sclk_nxt, r_ss, w_ss_nxt, r_ready, w_ready_nxt;
   logic r_busy, w_busy_nxt, r_done, w_done_nxt, w_start, w_phase_end;

   spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_start    (w_start),
      .o_phase_end(w_phase_end)
   );

   // spi_mosi is the shift register MSB; shifting on the falling edge presents the next bit.
   always_comb begin
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_bit_nxt   = r_bit;
      w_gap_nxt   = r_gap;
      w_sclk_nxt  = r_sclk;
      w_ss_nxt    = r_ss;
      w_ready_nxt = r_ready;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      w_start     = 1'b0;
      case (r_state)
         IDLE: if (in_valid && r_ready) begin
            w_state_nxt = SETUP;
            w_shift_nxt = encode_frame(in_blank, in_dp, in_data);
            w_bit_nxt   = '0;
            w_ss_nxt    = 1'b0;
            w_ready_nxt = 1'b0;
            w_busy_nxt  = 1'b1;
            w_start     = 1'b1;
         end
         SETUP: if (w_phase_end) begin
            w_state_nxt = SHIFT_HI;
            w_sclk_nxt  = 1'b1;
            w_start     = 1'b1;
         end
         SHIFT_HI: if (w_phase_end) begin
            w_state_nxt = SHIFT_LO;
            w_sclk_nxt  = 1'b0;
            w_shift_nxt = r_shift << 1;
            w_start     = 1'b1;
         end
         SHIFT_LO: if (w_phase_end) begin
            if (r_bit == 3'(FRAME_BITS - 1)) begin
               // With no gap the block is ready in the same cycle spi_ss rises.
               w_state_nxt = (GAP == 0) ? IDLE : spi_sevenseg_pkg::GAP;
               w_gap_nxt   = GW'(GAP > 0 ? GAP - 1 : 0);
               w_ss_nxt    = 1'b1;
               w_shift_nxt = '0;
               w_done_nxt  = 1'b1;
               w_ready_nxt = (GAP == 0);
               w_busy_nxt  = (GAP != 0);
            end else begin
               w_state_nxt = SHIFT_HI;
               w_sclk_nxt  = 1'b1;
               w_bit_nxt   = r_bit + 3'd1;
               w_start     = 1'b1;
            end
         end
         spi_sevenseg_pkg::GAP: if (r_gap == '0) begin
            w_state_nxt = IDLE;
            w_ready_nxt = 1'b1;
            w_busy_nxt  = 1'b0;
         end else begin
            w_gap_nxt = r_gap - GW'(1);
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_shift <= '0;
         r_bit   <= '0;
         r_gap   <= '0;
         r_sclk  <= 1'b0;
         r_ss    <= 1'b1;
         r_ready <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_shift <= w_shift_nxt;
         r_bit   <= w_bit_nxt;
         r_gap   <= w_gap_nxt;
         r_sclk  <= w_sclk_nxt;
         r_ss    <= w_ss_nxt;
         r_ready <= w_ready_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign in_ready = r_ready;
   assign spi_sclk = r_sclk;
   assign spi_ss   = r_ss;
   assign spi_mosi = r_shift[5];
   assign busy     = r_busy;
   assign done     = r_done;
endmodule
